// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode constants and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: one-hot winner, favouring the requester not granted last.
module rr_arb2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        if (req0_i && req1_i) begin
            win_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            win_o = 2'b01;
        end else if (req1_i) begin
            win_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared, fixed-latency ALU (WAIT_CYCLES legal 1..15).
// Define ALU_ARB_SELCHK_EN to reject SEL codes above OP_OR with an ERR pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [7:0] OP0_A,
    input  logic [7:0] OP0_B,
    input  logic [7:0] OP1_A,
    input  logic [7:0] OP1_B,
    input  logic [2:0] OP0_SEL,
    input  logic [2:0] OP1_SEL,
    output logic       GNT0,
    output logic       GNT1,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    output logic [7:0] RESULT,
    output logic       RESULT_ID,
    output logic       DONE,
    output logic       ERR
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             errp_q, errp_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [7:0]       d1_q, d1_d;
    logic [7:0]       d2_q, d2_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       res_q, res_d;
    logic             rid_q, rid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0]       win;
    logic             win_id;
    logic [2:0]       sel_w;
    logic             sel_bad;

    rr_arb2 u_rr (
        .req0_i (REQ0),
        .req1_i (REQ1),
        .last_i (last_q),
        .win_o  (win)
    );

    assign win_id = win[1];
    assign sel_w  = win_id ? OP1_SEL : OP0_SEL;

`ifdef ALU_ARB_SELCHK_EN
    assign sel_bad = (sel_w > OP_OR);
`else
    assign sel_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        errp_d  = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        d1_d    = d1_q;
        d2_d    = d2_q;
        sel_d   = sel_q;
        res_d   = res_q;
        rid_d   = rid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win != 2'b00) begin
                    state_d = S_BUSY;
                    gnt0_d  = win[0];
                    gnt1_d  = win[1];
                    last_d  = win_id;
                    owner_d = win_id;
                    if (sel_bad) begin
                        // Rejected op: ALU drive keeps its previous values.
                        errp_d = 1'b1;
                    end else begin
                        d1_d  = win_id ? OP1_A : OP0_A;
                        d2_d  = win_id ? OP1_B : OP0_B;
                        sel_d = sel_w;
                        cnt_d = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_BUSY: begin
                if (errp_q) begin
                    err_d   = 1'b1;
                    rid_d   = owner_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = ALU_RESULT;
                        rid_d   = owner_q;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            errp_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            d1_q    <= '0;
            d2_q    <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            rid_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            errp_q  <= errp_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            rid_q   <= rid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign ALU_DATA1  = d1_q;
    assign ALU_DATA2  = d2_q;
    assign ALU_SELECT = sel_q;
    assign RESULT     = res_q;
    assign RESULT_ID  = rid_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule
